ifu_fetch_responder: RTL and testbench
======================================

// Module: ifu_fetch_responder
// PURPOSE
//  Memory-side responder for the frontend fetch handshake (pc_index_valid / pc_index_ready /
//  pc_operation_done / pc_read_inst). Accepts one 16B-aligned fetch request at a time, reads
//  the line from the backing DDR port as BEATS beats, and returns it as one 128-bit word.
//  A 1-entry line buffer short-circuits repeat fetches of the same line. Sits between pc_ctrl
//  and the DDR arbiter.
// PARAMETERS
//  ADDR_WIDTH   64   request/DDR address width (bytes)
//  LINE_WIDTH   128  returned fetch line width; must equal `ICACHE_FETCHWIDTH128 width
//  BEAT_WIDTH   64   DDR read data width; localparam BEATS = LINE_WIDTH/BEAT_WIDTH (>=1)
//  LINE_BUF_EN  1    1: enable 1-entry line buffer; 0: every request goes to DDR
// PORTS
//  clock              in   1           single clock, rising edge
//  reset_n            in   1           synchronous, active-low reset
//  pc_index_valid     in   1           fetch request valid
//  pc_index           in   ADDR_WIDTH  fetch byte address; bits [3:0] ignored
//  pc_index_ready     out  1           request accepted when valid && ready
//  pc_operation_done  out  1           1-cycle pulse: pc_read_inst holds the requested line
//  pc_read_inst       out  LINE_WIDTH  returned line; stable from done until next done
//  redirect_valid     in   1           flush: kill outstanding request, no done for it
//  fence_i            in   1           invalidate line buffer
//  ddr_req_valid      out  1           DDR burst read request
//  ddr_req_ready      in   1           DDR accepts request
//  ddr_req_addr       out  ADDR_WIDTH  line base address {pc_index[63:4],4'b0}
//  ddr_resp_valid     in   1           one read beat valid
//  ddr_resp_data      in   BEAT_WIDTH  read beat, beat 0 = lowest address
// BEHAVIOUR
//  Reset (reset_n==0 at a rising edge): state=IDLE; pc_index_ready=0 for that cycle, then 1;
//   pc_operation_done=0; pc_read_inst=0; ddr_req_valid=0; ddr_req_addr=0; line buffer invalid;
//   beat counter=0. Reset mid-burst abandons the burst; stray DDR beats arriving in IDLE ignored.
//  FSM: IDLE -> (accept, buf hit) HIT | (accept, miss) REQ.
//   HIT -> IDLE: done next cycle (latency 1 from accept).
//   REQ: ddr_req_valid=1, addr held; on ddr_req_ready -> BEAT.
//   BEAT: each ddr_resp_valid writes beat[cnt] into pc_read_inst[cnt*BEAT_WIDTH +: BEAT_WIDTH],
//    cnt++; on last beat -> DONE. DONE: done=1, buffer tag/data updated, -> IDLE.
//   DRAIN: entered on redirect in BEAT; consume remaining beats, discard, no done, -> IDLE.
//  pc_index_ready = (state==IDLE) && !redirect_valid. Request captured into addr register on accept.
//  Redirect: in HIT or REQ-before-ready -> IDLE, no done, no DDR request issued/kept
//   (ddr_req_valid drops next cycle); in REQ with ddr_req_ready same cycle -> DRAIN; in BEAT
//   -> DRAIN; in DONE -> done still suppressed. Redirect in IDLE: no effect.
//  Line buffer: hit = valid && tag==pc_index[ADDR_WIDTH-1:4]. Filled only by a completed DONE.
//   fence_i or redirect does not touch the buffer contents except fence_i clears valid; fence_i
//   same cycle as accept: treated as miss. Killed (DRAIN) lines never fill the buffer.
//  pc_read_inst only changes on a write beat of a non-drain burst or on HIT; a killed burst must
//   not leave partial data visible at a later done (next done overwrites all beats).
//  At most one request outstanding; no back-to-back accept: ready low from accept until IDLE.
//  Throughput: miss = 1 (REQ) + DDR latency + BEATS + 1 cycles; hit = 1 cycle per request + 1 idle.
// STRUCTURE
//  Shared frontend defines header: FSM state encodings (IDLE,REQ,BEAT,DRAIN,HIT,DONE),
//   `ICACHE_FETCHWIDTH128_RANGE, line offset width (4).
//  One sub-module: fetch_line_buf (tag/data/valid regs, lookup, fill, invalidate).
//  Top: FSM, beat counter, address/data registers, DDR handshake.
// TESTING
//  Miss: pc_index=0x8000_0004, DDR beats 0x1111..,0x2222.. -> ddr_req_addr=0x8000_0000,
//   done 1 cycle after beat 1, pc_read_inst={0x2222..,0x1111..}.
//  Hit: re-request 0x8000_000C -> no ddr_req_valid, done exactly 1 cycle after accept, same data.
//  Redirect in BEAT after beat 0 -> no done; 2nd beat consumed; next request 0x9000_0000
//   returns its own line, buffer still holds 0x8000_0000 line.
//  ddr_req_ready held low 5 cycles -> ddr_req_valid/addr stable, pc_index_ready=0 throughout.
//  fence_i then request 0x8000_0000 -> DDR read issued (miss).
//  reset_n low during BEAT -> all outputs at reset values next cycle; late beat ignored; ready=1.

Source files
------------

// File: rtl/ifu_fetch_responder_pkg.sv
// Shared frontend fetch definitions: line geometry and responder FSM encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ifu_fetch_responder_pkg;

    // Fetch line is 16 bytes, so the low 4 address bits select a byte inside it.
    localparam int LINE_OFF_W = 4;
    localparam int FETCH_W    = 128;

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_REQ   = 3'd1;
    localparam logic [ST_W-1:0] ST_BEAT  = 3'd2;
    localparam logic [ST_W-1:0] ST_DRAIN = 3'd3;
    localparam logic [ST_W-1:0] ST_HIT   = 3'd4;
    localparam logic [ST_W-1:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/ifu_fetch_responder_line_buf.sv
// One-entry fetch line buffer: tag/data/valid, combinational lookup, fill, invalidate.
// Latency: lookup is combinational; fill and invalidate take effect the next cycle.
// Backpressure: none; fill and invalidate are accepted every cycle, invalidate wins.
module ifu_fetch_responder_line_buf #(
    parameter int TAG_W  = 60,
    parameter int LINE_W = 128,
    parameter bit EN     = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [TAG_W-1:0]  lookup_tag,
    output logic              hit,
    output logic [LINE_W-1:0] rd_data,
    input  logic              fill_en,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_data,
    input  logic              inval
);

    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;

    // Fill writes tag/data; an invalidate in the same cycle leaves the entry invalid.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else begin
            if (fill_en) begin
                tag  <= fill_tag;
                data <= fill_data;
            end
            if (inval) begin
                valid <= 1'b0;
            end else if (fill_en) begin
                valid <= 1'b1;
            end
        end
    end

    assign hit     = EN && valid && (tag == lookup_tag);
    assign rd_data = data;

endmodule

// File: rtl/ifu_fetch_responder.sv
// Fetch responder: one 16B line per request, from the line buffer or a DDR burst.
// Latency: hit 1 cycle after accept; miss 1 + DDR latency + BEATS + 1 cycles.
// Backpressure: pc_index_ready low from accept until back in IDLE; DDR request held until ready.
module ifu_fetch_responder
    import ifu_fetch_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int LINE_WIDTH  = FETCH_W,
    parameter int BEAT_WIDTH  = 64,
    parameter bit LINE_BUF_EN = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  pc_index_valid,
    input  logic [ADDR_WIDTH-1:0] pc_index,
    output logic                  pc_index_ready,
    output logic                  pc_operation_done,
    output logic [LINE_WIDTH-1:0] pc_read_inst,
    input  logic                  redirect_valid,
    input  logic                  fence_i,
    output logic                  ddr_req_valid,
    input  logic                  ddr_req_ready,
    output logic [ADDR_WIDTH-1:0] ddr_req_addr,
    input  logic                  ddr_resp_valid,
    input  logic [BEAT_WIDTH-1:0] ddr_resp_data
);

    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TAG_W = ADDR_WIDTH - LINE_OFF_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [ST_W-1:0]       state;
    logic [TAG_W-1:0]      addr_q;
    logic [CNT_W-1:0]      cnt;
    logic [LINE_WIDTH-1:0] fill_q;   // line being assembled from DDR beats
    logic [LINE_WIDTH-1:0] inst_q;   // last line handed out with a done
    logic                  accept;
    logic                  buf_hit;
    logic                  buf_fill;
    logic [LINE_WIDTH-1:0] buf_data;
    logic                  beat_last;
    logic [LINE_OFF_W-1:0] unused_ofs;

    assign unused_ofs = pc_index[LINE_OFF_W-1:0];

    assign pc_index_ready    = reset_n && (state == ST_IDLE) && !redirect_valid;
    assign accept            = pc_index_valid && pc_index_ready;
    assign beat_last         = (cnt == LAST_BEAT);
    assign pc_operation_done = ((state == ST_HIT) || (state == ST_DONE)) && !redirect_valid;
    assign buf_fill          = (state == ST_DONE) && !redirect_valid;
    assign ddr_req_valid     = (state == ST_REQ);
    assign ddr_req_addr      = {addr_q, {LINE_OFF_W{1'b0}}};

    ifu_fetch_responder_line_buf #(
        .TAG_W  (TAG_W),
        .LINE_W (LINE_WIDTH),
        .EN     (LINE_BUF_EN)
    ) u_line_buf (
        .clock      (clock),
        .reset_n    (reset_n),
        .lookup_tag (pc_index[ADDR_WIDTH-1:LINE_OFF_W]),
        .hit        (buf_hit),
        .rd_data    (buf_data),
        .fill_en    (buf_fill),
        .fill_tag   (addr_q),
        .fill_data  (fill_q),
        .inval      (fence_i)
    );

    // Present the new line during its done cycle so the output only moves when done is high.
    always_comb begin
        pc_read_inst = inst_q;
        if (!redirect_valid && (state == ST_HIT)) begin
            pc_read_inst = buf_data;
        end else if (!redirect_valid && (state == ST_DONE)) begin
            pc_read_inst = fill_q;
        end
    end

    // Request FSM, beat counter and line registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            addr_q <= '0;
            cnt    <= '0;
            fill_q <= '0;
            inst_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q <= pc_index[ADDR_WIDTH-1:LINE_OFF_W];
                        state  <= (buf_hit && !fence_i) ? ST_HIT : ST_REQ;
                    end
                end
                ST_HIT: begin
                    if (!redirect_valid) begin
                        inst_q <= buf_data;
                    end
                    state <= ST_IDLE;
                end
                ST_REQ: begin
                    if (ddr_req_ready) begin
                        state <= redirect_valid ? ST_DRAIN : ST_BEAT;
                    end else if (redirect_valid) begin
                        state <= ST_IDLE;
                    end
                end
                ST_BEAT: begin
                    if (ddr_resp_valid) begin
                        cnt <= cnt + 1'b1;
                        if (!redirect_valid) begin
                            fill_q[cnt*BEAT_WIDTH +: BEAT_WIDTH] <= ddr_resp_data;
                        end
                        if (beat_last) begin
                            cnt   <= '0;
                            state <= redirect_valid ? ST_IDLE : ST_DONE;
                        end else if (redirect_valid) begin
                            state <= ST_DRAIN;
                        end
                    end else if (redirect_valid) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (ddr_resp_valid) begin
                        cnt <= cnt + 1'b1;
                        if (beat_last) begin
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!redirect_valid) begin
                        inst_q <= fill_q;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch_responder.sv
// Bench for ifu_fetch_responder: directed handshake scenarios plus randomized fetches.
// Latency: expectations derived from a line-level memory and buffer model.
// Backpressure: DDR request latency and beat gaps varied by the stimulus.
module tb_ifu_fetch_responder;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         pc_index_valid;
    logic [63:0]  pc_index;
    logic         pc_index_ready;
    logic         pc_operation_done;
    logic [127:0] pc_read_inst;
    logic         redirect_valid;
    logic         fence_i;
    logic         ddr_req_valid;
    logic         ddr_req_ready;
    logic [63:0]  ddr_req_addr;
    logic         ddr_resp_valid;
    logic [63:0]  ddr_resp_data;

    int tests = 0;
    int fails = 0;

    // Reference model: buffer entry and the line most recently returned with a done.
    bit           m_valid;
    logic [59:0]  m_tag;
    logic [127:0] last_inst;

    always #5 clock = ~clock;

    ifu_fetch_responder dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .pc_index_valid    (pc_index_valid),
        .pc_index          (pc_index),
        .pc_index_ready    (pc_index_ready),
        .pc_operation_done (pc_operation_done),
        .pc_read_inst      (pc_read_inst),
        .redirect_valid    (redirect_valid),
        .fence_i           (fence_i),
        .ddr_req_valid     (ddr_req_valid),
        .ddr_req_ready     (ddr_req_ready),
        .ddr_req_addr      (ddr_req_addr),
        .ddr_resp_valid    (ddr_resp_valid),
        .ddr_resp_data     (ddr_resp_data)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Backing memory contents: beat b of the line containing byte address a.
    function automatic logic [63:0] beat_of(input logic [63:0] a, input int b);
        logic [31:0] t;
        t = a[35:4];
        if (a[63:4] == 60'h800_0000)
            return (b == 0) ? 64'h1111_1111_1111_1111 : 64'h2222_2222_2222_2222;
        return {32'hC0DE_0000 + 32'(b), t * 32'h9E37_79B9 + 32'(b)};
    endfunction

    // A line is its beats with beat 0 in the low half.
    function automatic logic [127:0] line_of(input logic [63:0] a);
        return ({64'h0, beat_of(a, 1)} << 64) | {64'h0, beat_of(a, 0)};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One complete fetch, entered and left just after a rising edge.
    task automatic fetch(input logic [63:0] a, input bit fence, input int req_lat, input int gap);
        bit           hit;
        logic [127:0] line;
        logic [63:0]  base;
        hit  = !fence && m_valid && (m_tag == a[63:4]);
        line = line_of(a);
        base = {a[63:4], 4'h0};
        pc_index_valid = 1'b1;
        pc_index       = a;
        fence_i        = fence;
        @(negedge clock);
        chk("req_ready", pc_index_ready, 1'b1);
        step();
        pc_index_valid = 1'b0;
        pc_index       = {$urandom, $urandom};
        fence_i        = 1'b0;
        if (fence) m_valid = 1'b0;
        if (hit) begin
            @(negedge clock);
            chk("hit_done", pc_operation_done, 1'b1);
            chk("hit_data", pc_read_inst, line);
            chk("hit_no_ddr", ddr_req_valid, 1'b0);
            chk("hit_busy", pc_index_ready, 1'b0);
            step();
        end else begin
            for (int i = 0; i <= req_lat; i++) begin
                if (i == req_lat) ddr_req_ready = 1'b1;
                @(negedge clock);
                chk("req_valid", ddr_req_valid, 1'b1);
                chk("req_addr", ddr_req_addr, base);
                chk("req_busy", pc_index_ready, 1'b0);
                chk("req_nodone", pc_operation_done, 1'b0);
                step();
            end
            ddr_req_ready = 1'b0;
            for (int b = 0; b < 2; b++) begin
                repeat (gap) begin
                    @(negedge clock);
                    chk("gap_nodone", pc_operation_done, 1'b0);
                    step();
                end
                ddr_resp_valid = 1'b1;
                ddr_resp_data  = beat_of(a, b);
                @(negedge clock);
                chk("beat_nodone", pc_operation_done, 1'b0);
                chk("beat_req_low", ddr_req_valid, 1'b0);
                chk("beat_inst_stable", pc_read_inst, last_inst);
                step();
                ddr_resp_valid = 1'b0;
                ddr_resp_data  = {$urandom, $urandom};
            end
            @(negedge clock);
            chk("miss_done", pc_operation_done, 1'b1);
            chk("miss_data", pc_read_inst, line);
            chk("miss_busy", pc_index_ready, 1'b0);
            step();
            m_valid = 1'b1;
            m_tag   = a[63:4];
        end
        last_inst = line;
        @(negedge clock);
        chk("after_nodone", pc_operation_done, 1'b0);
        chk("after_ready", pc_index_ready, 1'b1);
        chk("after_hold", pc_read_inst, line);
        step();
    endtask

    initial begin
        reset_n        = 1'b0;
        pc_index_valid = 1'b0;
        pc_index       = '0;
        redirect_valid = 1'b0;
        fence_i        = 1'b0;
        ddr_req_ready  = 1'b0;
        ddr_resp_valid = 1'b0;
        ddr_resp_data  = '0;
        m_valid        = 1'b0;
        m_tag          = '0;
        last_inst      = '0;

        // Reset values.
        step();
        @(negedge clock);
        chk("rst_ready", pc_index_ready, 1'b0);
        chk("rst_done", pc_operation_done, 1'b0);
        chk("rst_req", ddr_req_valid, 1'b0);
        chk("rst_addr", ddr_req_addr, 64'h0);
        chk("rst_inst", pc_read_inst, 128'h0);
        step();
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_release_ready", pc_index_ready, 1'b1);
        step();

        // Miss, then hit on the same line.
        fetch(64'h8000_0004, 1'b0, 1, 0);
        fetch(64'h8000_000C, 1'b0, 0, 0);

        // Redirect in BEAT after beat 0: drained, no done, buffer untouched.
        pc_index_valid = 1'b1;
        pc_index       = 64'h9000_0000;
        step();
        pc_index_valid = 1'b0;
        ddr_req_ready  = 1'b1;
        step();
        ddr_req_ready  = 1'b0;
        ddr_resp_valid = 1'b1;
        ddr_resp_data  = beat_of(64'h9000_0000, 0);
        step();
        ddr_resp_valid = 1'b0;
        redirect_valid = 1'b1;
        @(negedge clock);
        chk("rdr_beat_nodone", pc_operation_done, 1'b0);
        chk("rdr_beat_busy", pc_index_ready, 1'b0);
        step();
        redirect_valid = 1'b0;
        ddr_resp_valid = 1'b1;
        ddr_resp_data  = beat_of(64'h9000_0000, 1);
        @(negedge clock);
        chk("drain_nodone", pc_operation_done, 1'b0);
        chk("drain_busy", pc_index_ready, 1'b0);
        step();
        ddr_resp_valid = 1'b0;
        @(negedge clock);
        chk("drain_idle_ready", pc_index_ready, 1'b1);
        chk("drain_idle_nodone", pc_operation_done, 1'b0);
        chk("drain_inst_hold", pc_read_inst, last_inst);
        step();
        fetch(64'h8000_0008, 1'b0, 0, 0);
        fetch(64'h9000_0000, 1'b0, 2, 1);

        // DDR holds off the request for 5 cycles.
        fetch(64'h8000_0000, 1'b0, 5, 0);

        // Standalone fence_i, then the buffered line misses.
        fence_i = 1'b1;
        step();
        fence_i = 1'b0;
        m_valid = 1'b0;
        fetch(64'h8000_0000, 1'b0, 0, 0);

        // Redirect while a hit is being returned.
        pc_index_valid = 1'b1;
        pc_index       = 64'h8000_0004;
        step();
        pc_index_valid = 1'b0;
        redirect_valid = 1'b1;
        @(negedge clock);
        chk("rdr_hit_nodone", pc_operation_done, 1'b0);
        chk("rdr_hit_no_ddr", ddr_req_valid, 1'b0);
        chk("rdr_hit_inst", pc_read_inst, last_inst);
        step();
        redirect_valid = 1'b0;
        @(negedge clock);
        chk("rdr_hit_idle", pc_index_ready, 1'b1);
        chk("rdr_hit_idle_nodone", pc_operation_done, 1'b0);
        step();

        // Redirect while the DDR request is still waiting for ready.
        pc_index_valid = 1'b1;
        pc_index       = 64'hA000_0040;
        step();
        pc_index_valid = 1'b0;
        redirect_valid = 1'b1;
        @(negedge clock);
        chk("rdr_req_still", ddr_req_valid, 1'b1);
        chk("rdr_req_nodone", pc_operation_done, 1'b0);
        step();
        redirect_valid = 1'b0;
        @(negedge clock);
        chk("rdr_req_drop", ddr_req_valid, 1'b0);
        chk("rdr_req_ready", pc_index_ready, 1'b1);
        chk("rdr_req_idle_nodone", pc_operation_done, 1'b0);
        step();

        // Redirect in IDLE blocks acceptance.
        redirect_valid = 1'b1;
        pc_index_valid = 1'b1;
        pc_index       = 64'hA000_0080;
        @(negedge clock);
        chk("rdr_idle_ready", pc_index_ready, 1'b0);
        step();
        redirect_valid = 1'b0;
        pc_index_valid = 1'b0;
        @(negedge clock);
        chk("rdr_idle_noreq", ddr_req_valid, 1'b0);
        chk("rdr_idle_nodone", pc_operation_done, 1'b0);
        step();

        // Randomized fetches over a few hot lines plus random ones.
        for (int n = 0; n < 30; n++) begin
            logic [63:0] a;
            case ($urandom_range(0, 3))
                0:       a = 64'h8000_0000;
                1:       a = 64'h8000_0010;
                2:       a = 64'h9000_0000;
                default: a = {$urandom, $urandom};
            endcase
            a[3:0] = 4'($urandom_range(0, 15));
            fetch(a, ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // Reset in the middle of a burst; the late beat must be ignored.
        pc_index_valid = 1'b1;
        pc_index       = 64'hB000_0000;
        step();
        pc_index_valid = 1'b0;
        ddr_req_ready  = 1'b1;
        step();
        ddr_req_ready  = 1'b0;
        ddr_resp_valid = 1'b1;
        ddr_resp_data  = beat_of(64'hB000_0000, 0);
        step();
        ddr_resp_valid = 1'b0;
        reset_n        = 1'b0;
        @(negedge clock);
        chk("rst_mid_ready", pc_index_ready, 1'b0);
        step();
        reset_n   = 1'b1;
        m_valid   = 1'b0;
        last_inst = '0;
        @(negedge clock);
        chk("rst_mid_done", pc_operation_done, 1'b0);
        chk("rst_mid_inst", pc_read_inst, 128'h0);
        chk("rst_mid_req", ddr_req_valid, 1'b0);
        chk("rst_mid_addr", ddr_req_addr, 64'h0);
        chk("rst_mid_rdy", pc_index_ready, 1'b1);
        step();
        ddr_resp_valid = 1'b1;
        ddr_resp_data  = beat_of(64'hB000_0000, 1);
        @(negedge clock);
        chk("late_beat_nodone", pc_operation_done, 1'b0);
        chk("late_beat_ready", pc_index_ready, 1'b1);
        step();
        ddr_resp_valid = 1'b0;
        @(negedge clock);
        chk("late_idle_nodone", pc_operation_done, 1'b0);
        chk("late_idle_inst", pc_read_inst, 128'h0);
        step();
        fetch(64'h8000_0000, 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
